// File: rtl/bcd_conv_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// The converter drives the slave side and the producer of data_i drives the master side.
interface bcd_conv_seq_if #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
);
  logic [DATA_W-1:0]   data_i;
  logic                valid_i;
  logic                ready_o;
  logic [4*DIGITS-1:0] bcd_o;
  logic                valid_o;
  logic                overflow_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o,
    input  bcd_o,
    input  valid_o,
    input  overflow_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o,
    output bcd_o,
    output valid_o,
    output overflow_o
  );
endinterface

// File: rtl/bcd_conv_seq.sv
// Sequential double-dabble converter: one binary bit per cycle into DIGITS packed BCD
// nibbles, saturating to all nines when the value does not fit.
module bcd_conv_seq #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic clk_i,
  input  logic srst_i,
  bcd_conv_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  function automatic logic [BCD_W-1:0] sat_bcd(input logic ovf, input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    if (ovf) begin
      for (int k = 0; k < DIGITS; k++) begin
        r[4*k +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q;
  logic [BCD_W-1:0]    scratch_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_q;
  logic [BCD_W-1:0]    bcd_q;
  logic                ovf_out_q;
  logic                vld_q;

  logic                accept;
  logic                last;
  logic                ready;
  logic [BCD_W-1:0]    adj;
  logic [BCD_W-1:0]    scratch_nxt;
  logic [DATA_W-1:0]   shift_nxt;
  logic                shift_out;
  logic                ovf_nxt;

  // One double-dabble iteration: correct every digit, then shift {scratch, shift} left.
  always_comb begin
    adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      adj[4*k +: 4] = dabble_adj(scratch_q[4*k +: 4]);
    end
    {shift_out, scratch_nxt, shift_nxt} = {adj, shift_q, 1'b0};
    ovf_nxt = ovf_q | shift_out;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.valid_i) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      ovf_out_q <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      vld_q <= last;
      if (accept) begin
        shift_q   <= bus.data_i;
        scratch_q <= '0;
        cnt_q     <= '0;
        ovf_q     <= 1'b0;
      end else if (state_q == SHIFT) begin
        shift_q   <= shift_nxt;
        scratch_q <= scratch_nxt;
        cnt_q     <= cnt_q + CNT_W'(1);
        ovf_q     <= ovf_nxt;
      end
      // Result registers change only on completion; a new accept leaves them alone.
      if (last) begin
        bcd_q     <= sat_bcd(ovf_nxt, scratch_nxt);
        ovf_out_q <= ovf_nxt;
      end
    end
  end

  assign bus.ready_o    = ready;
  assign bus.bcd_o      = bcd_q;
  assign bus.valid_o    = vld_q;
  assign bus.overflow_o = ovf_out_q;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Bench for bcd_conv_seq: three instances cover the default, narrow-digit and wide-input
// configurations, checked against a decimal reference built from div/mod arithmetic.
module tb_bcd_conv_seq;

  logic clk;
  logic srst;
  int   n_cmp;
  int   n_bad;

  bcd_conv_seq_if #(.DATA_W(8),  .DIGITS(3)) a_if ();
  bcd_conv_seq_if #(.DATA_W(8),  .DIGITS(2)) b_if ();
  bcd_conv_seq_if #(.DATA_W(10), .DIGITS(4)) c_if ();

  bcd_conv_seq #(.DATA_W(8),  .DIGITS(3)) dut_a (.clk_i(clk), .srst_i(srst), .bus(a_if));
  bcd_conv_seq #(.DATA_W(8),  .DIGITS(2)) dut_b (.clk_i(clk), .srst_i(srst), .bus(b_if));
  bcd_conv_seq #(.DATA_W(10), .DIGITS(4)) dut_c (.clk_i(clk), .srst_i(srst), .bus(c_if));

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int v, input int digits);
    int lim;
    int x;
    logic [15:0] r;
    lim = 1;
    r = '0;
    for (int k = 0; k < digits; k++) lim = lim * 10;
    if (v >= lim) begin
      for (int k = 0; k < digits; k++) r[4*k +: 4] = 4'd9;
    end else begin
      x = v;
      for (int k = 0; k < digits; k++) begin
        r[4*k +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v, input int digits);
    int lim;
    lim = 1;
    for (int k = 0; k < digits; k++) lim = lim * 10;
    return (v >= lim);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [7:0] v, output logic [11:0] b, output logic o,
                       output int lat, output int rlow);
    a_if.data_i  = v;
    a_if.valid_i = 1'b1;
    tick();
    a_if.valid_i = 1'b0;
    lat  = -1;
    rlow = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_if.valid_o) begin
        lat = i;
        break;
      end
      if (!a_if.ready_o) rlow++;
      tick();
    end
    b = a_if.bcd_o;
    o = a_if.overflow_o;
  endtask

  task automatic run_b(input logic [7:0] v, output logic [7:0] b, output logic o, output int lat);
    b_if.data_i  = v;
    b_if.valid_i = 1'b1;
    tick();
    b_if.valid_i = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (b_if.valid_o) begin
        lat = i;
        break;
      end
      tick();
    end
    b = b_if.bcd_o;
    o = b_if.overflow_o;
  endtask

  task automatic run_c(input logic [9:0] v, output logic [15:0] b, output logic o, output int lat);
    c_if.data_i  = v;
    c_if.valid_i = 1'b1;
    tick();
    c_if.valid_i = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (c_if.valid_o) begin
        lat = i;
        break;
      end
      tick();
    end
    b = c_if.bcd_o;
    o = c_if.overflow_o;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    tick();
    tick();
    n_cmp += 4;
    if (a_if.ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready_a: got %b want 1", a_if.ready_o); end
    if (a_if.valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid_a: got %b want 0", a_if.valid_o); end
    if (a_if.bcd_o !== 12'h000) begin n_bad++; $display("FAIL reset_bcd_a: got %h want 000", a_if.bcd_o); end
    if (a_if.overflow_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovf_a: got %b want 0", a_if.overflow_o); end
    n_cmp += 2;
    if (b_if.ready_o !== 1'b1 || b_if.bcd_o !== 8'h00) begin
      n_bad++; $display("FAIL reset_b: got ready=%b bcd=%h want ready=1 bcd=00", b_if.ready_o, b_if.bcd_o);
    end
    if (c_if.ready_o !== 1'b1 || c_if.bcd_o !== 16'h0000 || c_if.valid_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_c: got ready=%b bcd=%h valid=%b want 1/0000/0", c_if.ready_o, c_if.bcd_o, c_if.valid_o);
    end
    srst = 1'b0;
    tick();
  endtask

  task automatic test_reset_wins();
    int pulses;
    srst = 1'b1;
    a_if.data_i  = 8'd5;
    a_if.valid_i = 1'b1;
    tick();
    srst = 1'b0;
    a_if.valid_i = 1'b0;
    n_cmp++;
    if (a_if.ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_wins_ready: got %b want 1", a_if.ready_o); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (a_if.valid_o) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses != 0) begin n_bad++; $display("FAIL reset_wins_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_single();
    logic [11:0] b;
    logic o;
    int lat, rlow;
    run_a(8'd255, b, o, lat, rlow);
    n_cmp += 4;
    if (lat != 8)      begin n_bad++; $display("FAIL single_latency: got %0d want 8", lat); end
    if (rlow != 8)     begin n_bad++; $display("FAIL single_ready_low: got %0d want 8", rlow); end
    if (b !== 12'h255) begin n_bad++; $display("FAIL single_bcd: got %h want 255", b); end
    if (o !== 1'b0)    begin n_bad++; $display("FAIL single_ovf: got %b want 0", o); end
    tick();
    n_cmp += 2;
    if (a_if.valid_o !== 1'b0) begin n_bad++; $display("FAIL single_pulse_width: got %b want 0", a_if.valid_o); end
    if (a_if.bcd_o !== 12'h255) begin n_bad++; $display("FAIL single_hold: got %h want 255", a_if.bcd_o); end
  endtask

  task automatic test_back_to_back();
    int vals[3];
    int when[3];
    int k, cyc;
    logic [15:0] exp;
    vals[0] = 0; vals[1] = 6; vals[2] = 100;
    when[0] = -1; when[1] = -1; when[2] = -1;
    k = 0;
    cyc = 0;
    a_if.data_i  = 8'(vals[0]);
    a_if.valid_i = 1'b1;
    tick();
    a_if.data_i = 8'(vals[1]);
    for (int i = 0; i < 100 && k < 3; i++) begin
      tick();
      cyc++;
      if (a_if.valid_o) begin
        exp = ref_bcd(vals[k], 3);
        n_cmp++;
        if (16'(a_if.bcd_o) !== exp) begin
          n_bad++; $display("FAIL b2b_bcd[%0d]: got %h want %h", k, a_if.bcd_o, exp);
        end
        when[k] = cyc;
        k++;
        if (k < 3) a_if.data_i = 8'(vals[k]);
        else a_if.valid_i = 1'b0;
      end
    end
    a_if.valid_i = 1'b0;
    n_cmp += 3;
    if (when[0] != 8) begin n_bad++; $display("FAIL b2b_first: got %0d want 8", when[0]); end
    if (when[1] - when[0] != 9) begin n_bad++; $display("FAIL b2b_gap1: got %0d want 9", when[1] - when[0]); end
    if (when[2] - when[1] != 9) begin n_bad++; $display("FAIL b2b_gap2: got %0d want 9", when[2] - when[1]); end
    tick();
  endtask

  task automatic test_busy();
    int v, pulses;
    logic [11:0] got;
    logic [15:0] exp;
    v = int'($urandom_range(1, 255));
    if (v == 42) v = 43;
    a_if.data_i  = 8'(v);
    a_if.valid_i = 1'b1;
    tick();
    a_if.data_i = 8'd42;
    pulses = 0;
    got = '0;
    for (int i = 0; i < 30; i++) begin
      if (a_if.valid_o) begin
        pulses++;
        if (pulses == 1) got = a_if.bcd_o;
        a_if.valid_i = 1'b0;
      end
      tick();
    end
    a_if.valid_i = 1'b0;
    exp = ref_bcd(v, 3);
    n_cmp += 2;
    if (pulses != 1) begin n_bad++; $display("FAIL busy_pulses: got %0d want 1", pulses); end
    if (16'(got) !== exp) begin n_bad++; $display("FAIL busy_bcd: got %h want %h (v=%0d)", got, exp, v); end
  endtask

  task automatic test_reset_mid();
    int pulses, lat, rlow;
    logic [11:0] b;
    logic o;
    a_if.data_i  = 8'd200;
    a_if.valid_i = 1'b1;
    tick();
    a_if.valid_i = 1'b0;
    tick();
    tick();
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    n_cmp += 4;
    if (a_if.valid_o !== 1'b0)  begin n_bad++; $display("FAIL mid_reset_valid: got %b want 0", a_if.valid_o); end
    if (a_if.bcd_o !== 12'h000) begin n_bad++; $display("FAIL mid_reset_bcd: got %h want 000", a_if.bcd_o); end
    if (a_if.ready_o !== 1'b1)  begin n_bad++; $display("FAIL mid_reset_ready: got %b want 1", a_if.ready_o); end
    if (a_if.overflow_o !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ovf: got %b want 0", a_if.overflow_o); end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (a_if.valid_o) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses != 0) begin n_bad++; $display("FAIL mid_reset_pulses: got %0d want 0", pulses); end
    run_a(8'd37, b, o, lat, rlow);
    n_cmp += 2;
    if (b !== 12'h037) begin n_bad++; $display("FAIL mid_reset_next_bcd: got %h want 037", b); end
    if (lat != 8)      begin n_bad++; $display("FAIL mid_reset_next_lat: got %0d want 8", lat); end
  endtask

  task automatic test_random_a();
    int v, lat, rlow;
    logic [11:0] b;
    logic o;
    logic [15:0] exp;
    for (int i = 0; i < 24; i++) begin
      v = int'($urandom_range(0, 255));
      run_a(8'(v), b, o, lat, rlow);
      exp = ref_bcd(v, 3);
      n_cmp += 3;
      if (16'(b) !== exp)          begin n_bad++; $display("FAIL rand_a_bcd: got %h want %h (v=%0d)", b, exp, v); end
      if (o !== ref_ovf(v, 3))     begin n_bad++; $display("FAIL rand_a_ovf: got %b want 0 (v=%0d)", o, v); end
      if (lat != 8)                begin n_bad++; $display("FAIL rand_a_lat: got %0d want 8 (v=%0d)", lat, v); end
    end
  endtask

  task automatic test_overflow_b();
    int v, lat;
    logic [7:0] b;
    logic o;
    logic [15:0] exp;
    logic eo;
    run_b(8'd100, b, o, lat);
    n_cmp += 2;
    if (b !== 8'h99) begin n_bad++; $display("FAIL ovf_100_bcd: got %h want 99", b); end
    if (o !== 1'b1)  begin n_bad++; $display("FAIL ovf_100_flag: got %b want 1", o); end
    tick();
    tick();
    n_cmp++;
    if (b_if.overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_hold: got %b want 1", b_if.overflow_o); end
    run_b(8'd99, b, o, lat);
    n_cmp += 2;
    if (b !== 8'h99) begin n_bad++; $display("FAIL ovf_99_bcd: got %h want 99", b); end
    if (o !== 1'b0)  begin n_bad++; $display("FAIL ovf_99_flag: got %b want 0", o); end
    for (int i = 0; i < 24; i++) begin
      v = int'($urandom_range(0, 255));
      run_b(8'(v), b, o, lat);
      exp = ref_bcd(v, 2);
      eo  = ref_ovf(v, 2);
      n_cmp += 2;
      if (16'(b) !== exp) begin n_bad++; $display("FAIL rand_b_bcd: got %h want %h (v=%0d)", b, exp, v); end
      if (o !== eo)       begin n_bad++; $display("FAIL rand_b_ovf: got %b want %b (v=%0d)", o, eo, v); end
    end
  endtask

  task automatic test_sweep_c();
    int lat;
    logic [15:0] b;
    logic o;
    logic [15:0] exp;
    for (int v = 0; v < 1024; v++) begin
      run_c(10'(v), b, o, lat);
      exp = ref_bcd(v, 4);
      n_cmp += 3;
      if (b !== exp)  begin n_bad++; $display("FAIL sweep_bcd: got %h want %h (v=%0d)", b, exp, v); end
      if (o !== 1'b0) begin n_bad++; $display("FAIL sweep_ovf: got %b want 0 (v=%0d)", o, v); end
      if (lat != 10)  begin n_bad++; $display("FAIL sweep_lat: got %0d want 10 (v=%0d)", lat, v); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clk = 1'b0;
    srst = 1'b1;
    a_if.data_i = '0; a_if.valid_i = 1'b0;
    b_if.data_i = '0; b_if.valid_i = 1'b0;
    c_if.data_i = '0; c_if.valid_i = 1'b0;
    test_reset();
    test_reset_wins();
    test_single();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    test_random_a();
    test_overflow_b();
    test_sweep_c();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
